// File: rtl/pipe_stage_skid.sv
// Flow-controlled pipeline stage register with optional two-entry skid buffer,
// synchronous flush and a saturating back-pressure (stall) counter.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH       = 32,
  parameter bit               SKID_EN     = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,      // active-high asynchronous reset despite the name
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             acc, drain;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign stall_cnt = stall_q;
  assign acc       = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // The skid variant decodes ready from state flops only, so out_ready never
  // reaches in_ready; reset gating keeps the stage closed while rst_n is high.
  generate
    if (SKID_EN) begin : g_skid
      assign in_ready = ~rst_n & (state_q != ST_FULL);
    end else begin : g_no_skid
      assign in_ready = ~rst_n & (~out_valid | out_ready);
    end
  endgenerate

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = RESET_VALUE;
      skid_d  = RESET_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (acc && drain) begin
            main_d = in_data;
          end else if (acc && SKID_EN) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // The skid entry is older than anything not yet accepted, so it moves up first.
          if (drain) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = RESET_VALUE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && !flush && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the payload registers are reset too, because out_data must show RESET_VALUE.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule
